instruction_fetch_stage: RTL and testbench

//  Fetch stage feeding the IF/ID register, which is read by the ID stage and the hazard unit.

---
 rtl/instruction_fetch_stage.sv | 154 +++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory, parks one returned word
// in a skid register during a load-use stall and applies branch flushes.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] target_branch_address_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] IR_IF_o,
   output logic [31:0] PC_IF_o,
   output logic        valid_IF_o
);

   // HOLD doubles as "skid full": the skid is only ever occupied in HOLD.
   typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] skid_insn_q, skid_insn_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] pc_if_q, pc_if_d;
   logic        valid_q, valid_d;
   logic        req;
   logic [31:0] target_aligned;

   assign target_aligned = target_branch_address_i & 32'hFFFF_FFFC;

   // Next-state, handshake and IF/ID update; flush overrides everything last.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      skid_insn_d = skid_insn_q;
      skid_pc_d   = skid_pc_q;
      ir_d        = ir_q;
      pc_if_d     = pc_if_q;
      valid_d     = valid_q;
      req         = 1'b0;

      // Without a stall the IF/ID register drains to a bubble unless a new
      // instruction is written below.
      if (!stall_i) begin
         ir_d    = NOP_INSN;
         valid_d = 1'b0;
      end

      unique case (state_q)
         FETCH: begin
            req = !flush_i;
            if (req && imem_gnt_i) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid_i) begin
               if (!stall_i) begin
                  ir_d    = imem_rdata_i;
                  pc_if_d = req_pc_q;
                  valid_d = 1'b1;
                  // Back-to-back fetch in the same cycle as the response.
                  req     = !flush_i;
                  if (req && imem_gnt_i) begin
                     req_pc_d = pc_q;
                     pc_d     = pc_q + 32'd4;
                  end else begin
                     state_d = FETCH;
                  end
               end else begin
                  skid_insn_d = imem_rdata_i;
                  skid_pc_d   = req_pc_q;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (!stall_i) begin
               ir_d    = skid_insn_q;
               pc_if_d = skid_pc_q;
               valid_d = 1'b1;
               state_d = FETCH;
            end
         end
         DISCARD: begin
            // The wrong-path response is simply dropped.
            if (imem_rvalid_i) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      // Branch flush: redirect, bubble IF/ID (PC field kept), drop the skid.
      if (flush_i) begin
         pc_d     = target_aligned;
         ir_d     = NOP_INSN;
         valid_d  = 1'b0;
         pc_if_d  = pc_if_q;
         req_pc_d = req_pc_q;
         if ((state_q == WAIT || state_q == DISCARD) && !imem_rvalid_i) begin
            state_d = DISCARD;
         end else begin
            state_d = FETCH;
         end
      end
   end

   // State and IF/ID registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'h0;
         skid_insn_q <= 32'h0;
         skid_pc_q   <= 32'h0;
         ir_q        <= NOP_INSN;
         pc_if_q     <= 32'h0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         skid_insn_q <= skid_insn_d;
         skid_pc_q   <= skid_pc_d;
         ir_q        <= ir_d;
         pc_if_q     <= pc_if_d;
         valid_q     <= valid_d;
      end
   end

   // Request is held low while reset is asserted.
   assign imem_req_o  = req & rst_ni;
   assign imem_addr_o = pc_q;
   assign IR_IF_o     = ir_q;
   assign PC_IF_o     = pc_if_q;
   assign valid_IF_o  = valid_q;

   // A response can only be legal while a request is outstanding.
   rvalid_only_when_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
      imem_rvalid_i |-> (state_q == WAIT || state_q == DISCARD));

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: transaction-level model (PC, one
// in-flight fetch with a killed flag, optional skid entry) compared every
// cycle, plus directed sequences with literal expectations.
module tb_instruction_fetch_stage;

   localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush, gnt, rvalid;
   logic [31:0] target, rdata;
   logic        req, valid;
   logic [31:0] addr, ir, pcif;

   always #5 clk = ~clk;

   instruction_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSN(NOP)) dut (
      .clk_i                   (clk),
      .rst_ni                  (rst_n),
      .stall_i                 (stall),
      .flush_i                 (flush),
      .target_branch_address_i (target),
      .imem_req_o              (req),
      .imem_addr_o             (addr),
      .imem_gnt_i              (gnt),
      .imem_rvalid_i           (rvalid),
      .imem_rdata_i            (rdata),
      .IR_IF_o                 (ir),
      .PC_IF_o                 (pcif),
      .valid_IF_o              (valid)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model
   logic [31:0] m_pc, m_ir, m_pcif, m_busy_addr, m_skid_insn, m_skid_pc;
   bit          m_valid, m_busy, m_killed, m_skid;

   // Instruction memory responder
   bit          mem_pend;
   logic [31:0] mem_data;
   int          mem_wait;
   int          dly_min = 1;
   int          dly_max = 1;
   bit          rand_data = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc     = RST_PC;
      m_ir     = NOP;
      m_pcif   = 32'h0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
      m_killed = 1'b0;
      m_skid   = 1'b0;
      mem_pend = 1'b0;
      mem_wait = 0;
   endtask

   // One clock cycle: drive inputs, compare outputs to model, advance model.
   task automatic step(input bit s, input bit f, input logic [31:0] t, input bit g);
      bit          exp_req, resp, acc, got;
      logic [31:0] gi, gp;
      @(posedge clk);
      #1;
      stall  = s;
      flush  = f;
      target = t;
      gnt    = g;
      rvalid = mem_pend && (mem_wait == 0);
      rdata  = rvalid ? mem_data : $urandom;
      #3;
      exp_req = !f && !m_skid && (!m_busy || (rvalid && !m_killed && !s));
      chk1("imem_req", req, exp_req);
      if (exp_req) chk32("imem_addr", addr, m_pc);
      chk32("IR_IF", ir, m_ir);
      chk32("PC_IF", pcif, m_pcif);
      chk1("valid_IF", valid, m_valid);

      // memory side: one response per grant, 1..dly_max cycles later
      if (rvalid) mem_pend = 1'b0;
      else if (mem_pend) mem_wait--;
      if (req && g) begin
         chk1("one_outstanding", mem_pend, 1'b0);
         mem_pend = 1'b1;
         mem_wait = int'($urandom_range(dly_max, dly_min)) - 1;
         mem_data = rand_data ? $urandom : addr;
      end

      // model advance
      resp = rvalid && m_busy;
      acc  = exp_req && g;
      got  = 1'b0;
      gi   = 32'h0;
      gp   = 32'h0;
      if (f) begin
         m_pc    = t & 32'hFFFF_FFFC;
         m_ir    = NOP;
         m_valid = 1'b0;
         m_skid  = 1'b0;
         if (resp) m_busy = 1'b0;
         else if (m_busy) m_killed = 1'b1;
      end else begin
         if (m_skid && !s) begin
            got    = 1'b1;
            gi     = m_skid_insn;
            gp     = m_skid_pc;
            m_skid = 1'b0;
         end else if (resp && !m_killed) begin
            if (!s) begin
               got = 1'b1;
               gi  = rdata;
               gp  = m_busy_addr;
            end else begin
               m_skid      = 1'b1;
               m_skid_insn = rdata;
               m_skid_pc   = m_busy_addr;
            end
         end
         if (resp) m_busy = 1'b0;
         if (acc) begin
            m_busy      = 1'b1;
            m_killed    = 1'b0;
            m_busy_addr = m_pc;
            m_pc        = m_pc + 32'd4;
         end
         if (got) begin
            m_ir    = gi;
            m_pcif  = gp;
            m_valid = 1'b1;
            $display("insn cycle %0d pc=%h ir=%h", cyc, gp, gi);
         end else if (!s) begin
            m_ir    = NOP;
            m_valid = 1'b0;
         end
      end
      cyc++;
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must reset at once.
   task automatic reset_pulse();
      @(posedge clk);
      #2;
      rst_n  = 1'b0;
      stall  = 1'b0;
      flush  = 1'b0;
      gnt    = 1'b0;
      rvalid = 1'b0;
      #1;
      chk1("rst_req", req, 1'b0);
      chk32("rst_IR", ir, NOP);
      chk32("rst_PC", pcif, 32'h0);
      chk1("rst_valid", valid, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] seq_exp [5];
      seq_exp = '{32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
      rst_n  = 1'b0;
      stall  = 1'b0;
      flush  = 1'b0;
      gnt    = 1'b0;
      rvalid = 1'b0;
      target = 32'h0;
      rdata  = 32'h0;

      // Sequential fetch with wrap from RESET_PC
      reset_pulse();
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk32("seq_first_addr", addr, RST_PC);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk32("wrap_addr", addr, 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1);
         chk32("seq_PC", pcif, seq_exp[k]);
         chk32("seq_IR", ir, seq_exp[k]);
         chk1("seq_valid", valid, 1'b1);
      end

      // Load-use stall while the fetch of 8 is in flight
      reset_pulse();
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b1);
      chk32("lu_PC3", pcif, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk32("lu_PC4", pcif, 32'h4);
      chk1("lu_req4", req, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk32("lu_PC5", pcif, 32'h4);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk32("lu_PC6", pcif, 32'h4);
      chk1("lu_valid6", valid, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk32("lu_PC7", pcif, 32'h8);
      chk32("lu_IR7", ir, 32'h8);
      chk32("lu_addr7", addr, 32'hC);

      // Branch flush while waiting for rvalid
      reset_pulse();
      dly_min = 2;
      dly_max = 2;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 32'h0000_0103, 1'b0);
      chk1("br_req_flush", req, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk1("br_req_discard", req, 1'b0);
      chk1("br_valid", valid, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk1("br_req", req, 1'b1);
      chk32("br_addr", addr, 32'h0000_0100);
      chk1("br_valid2", valid, 1'b0);
      chk32("br_IR", ir, NOP);

      // Flush and stall together in HOLD
      reset_pulse();
      dly_min = 1;
      dly_max = 1;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 32'h2000_0040, 1'b0);
      chk1("fs_req", req, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk1("fs_valid", valid, 1'b0);
      chk32("fs_addr", addr, 32'h2000_0040);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk1("fs_valid2", valid, 1'b0);

      // Slow grant, then reset in the middle of WAIT
      reset_pulse();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0);
         chk32("slow_addr", addr, RST_PC);
         chk1("slow_valid", valid, 1'b0);
      end
      dly_min = 3;
      dly_max = 3;
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk32("slow_addr_gnt", addr, RST_PC);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      reset_pulse();
      step(1'b0, 1'b0, 32'h0, 1'b1);
      chk1("postrst_req", req, 1'b1);
      chk32("postrst_addr", addr, RST_PC);

      // Randomized traffic
      dly_min   = 1;
      dly_max   = 3;
      rand_data = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(3, 0) == 0, $urandom_range(11, 0) == 0, $urandom,
              $urandom_range(4, 0) < 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
